// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/writeback controller for the datapath ALU.
// Takes 16-bit instructions in register or immediate form over a valid/ready
// handshake, reads operands from a 16x16 register file, drives the ALU for one
// cycle, and then writes back the result and the 5-bit status register.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   instr_valid/instr   instruction word offered by the producer
//   instr_ready         high only in IDLE (decoded from the state register)
//   alu_a/alu_b         registered ALU operands (Rdest value, Rsrc value or imm)
//   alu_opcode          registered ALU opcode
//   alu_cin             carry-in, psr[3]
//   alu_c/alu_flags     combinational ALU result and flags {Z,C,O,L,N}
//   psr                 status register, same bit order as alu_flags
//   done/illegal        one-cycle retire / reject pulses
//   dbg_addr/dbg_data   combinational register file read port
module alu_issue_ctrl #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [4:0]       alu_flags,
  output logic [4:0]       psr,
  output logic             done,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_ADD  = 4'b0101,
    OP_ADDU = 4'b0110,
    OP_ADDC = 4'b0111,
    OP_SUB  = 4'b1001,
    OP_SUBC = 4'b1010,
    OP_CMP  = 4'b1011,
    OP_MOV  = 4'b1101
  } op_t;

  state_t           state;
  logic [15:0]      instr_q;
  logic [3:0]       op_q;
  logic [3:0]       rd_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flags_q;
  logic [WIDTH-1:0] regs [NREGS];

  // The signed-arithmetic ops are exactly the ones that sign-extend their
  // immediate and load the ALU flags into psr.
  function automatic logic arith_signed(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: arith_signed = 1'b1;
      default:                                  arith_signed = 1'b0;
    endcase
  endfunction

  logic             reg_form;
  logic [3:0]       dec_op;
  logic [3:0]       dec_rd;
  logic [3:0]       dec_rs;
  logic             dec_legal;
  logic [WIDTH-1:0] dec_b;

  always_comb begin
    reg_form = (instr_q[15:12] == 4'b0000);
    dec_op   = reg_form ? instr_q[7:4] : instr_q[15:12];
    dec_rd   = instr_q[11:8];
    dec_rs   = instr_q[3:0];
    case (dec_op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
      OP_SUB, OP_SUBC, OP_CMP, OP_MOV: dec_legal = 1'b1;
      default:                         dec_legal = 1'b0;
    endcase
    if (reg_form)
      dec_b = regs[dec_rs];
    else if (arith_signed(dec_op))
      dec_b = {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]};
    else
      dec_b = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      illegal    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      psr        <= '0;
      instr_q    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= IDLE;
          end else begin
            op_q       <= dec_op;
            rd_q       <= dec_rd;
            opb_q      <= dec_b;
            alu_a      <= regs[dec_rd];
            alu_b      <= dec_b;
            alu_opcode <= dec_op;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_c;
          flags_q <= alu_flags;
          state   <= WB;
        end
        WB: begin
          // MOV takes operand B straight from decode, not from the ALU.
          if (op_q != OP_CMP)
            regs[rd_q] <= (op_q == OP_MOV) ? opb_q : res_q;
          if (arith_signed(op_q))
            psr <= flags_q;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign alu_cin     = psr[3];
  assign dbg_data    = regs[dbg_addr];

endmodule
